ripple_down_counter_4b: RTL and testbench
=========================================

// Module: ripple_down_counter_4b
// PURPOSE
//   4-bit down counter built as a chain of toggle (T) flip-flop stages, with a
//   global count-enable T. Each rising clk edge with T=1 decrements q by one,
//   wrapping 0 -> 15. T=0 freezes q without losing its value.
//   Used as a small free-running or pausable event/divider counter.
// PARAMETERS
//   WIDTH      4   number of counter stages (bits of q); spec and tests assume 4
// PORTS
//   clk   in   1      rising-edge clock; sole clock of the block
//   rst   in   1      synchronous, active-high reset
//   T     in   1      count enable: 1 = count down, 0 = hold
//   q     out  WIDTH  current count, unsigned; q[0] is the LSB
//   Instantiation port order is positional (q, clk, rst, T).
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. Name the ports clk and rst.
//   - Reset: on a rising clk edge with rst=1, q <= 0. rst has priority over T.
//     q is undefined (X) until the first reset edge; there is no power-on init.
//   - Count: on a rising clk edge with rst=0 and T=1, q <= q - 1 (mod 2^WIDTH).
//     0 -> 15 on wrap. The first count edge after reset gives q = 15.
//   - Hold: on a rising clk edge with rst=0 and T=0, q is unchanged.
//     The next edge with T=1 resumes from the held value.
//   - Latency: q updates on the same rising edge that samples rst and T.
//     There is no combinational path from inputs to q.
//   - Stage rule (down-count toggle condition):
//       stage 0 toggles when T=1;
//       stage i toggles when T=1 and q[i-1:0] are all 0.
//     All stages are clocked by clk, so every bit of q changes on the same edge.
//     There are no intermediate or ripple glitch states visible on q.
//   - Reset mid-count: asserting rst overrides the count on that edge (q <= 0).
//     Releasing rst with T=1 gives q = 15 on the next edge.
//   - Simultaneous rst=1 and T=0: reset wins, q <= 0.
//   - rst and T are sampled only at rising clk edges; pulses between edges
//     have no effect.
// STRUCTURE
//   - Sub-module t_ff_stage:
//       ports: clk, rst, t, q
//       behaviour: synchronous reset to 0; q <= q ^ t.
//   - Top level: generate loop over WIDTH instances of t_ff_stage, plus the
//     borrow/enable chain en[i] = en[i-1] & ~q[i-1], with en[0] = T.
//   - Shared package (counter_pkg): WIDTH default constant and the reset
//     value constant (all-zeros).
// TESTING (clk period 20, rising edges at t = 10, 30, 50, ...)
//   1. rst=1 at t=0, edge at 10 -> q = 0.
//      Release rst at 15 with T=1 -> q = 15, 14, 13, 12 at edges 30, 50, 70, 90.
//   2. T=0 at 105 -> q holds 12 at edges 110, 130, 150.
//      T=1 at 155 -> q = 11 at 170, q = 10 at 190.
//   3. rst=1 at 195 while T=1 -> q = 0 at edge 210.
//      rst=0 at 215 -> q = 15 at 230, q = 14 at 250.
//   4. Wrap: from q = 1 with T=1 -> q = 0, then q = 15 on the next edge.
//      Run 16 edges from 15 and check a full cycle back to 15.
//   5. rst=1 with T=0 -> q = 0 (reset priority).
//      A pulse on rst or T between clock edges leaves q unchanged.
//   6. Scoreboard: at every edge compare q against the reference model
//      q_ref = rst ? 0 : T ? q_ref - 1 : q_ref.
//      Also assert that q changes only on rising clk edges.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the toggle-stage down counter.
// Latency: n/a (constants only).
// Backpressure: none.
package counter_pkg;

    localparam int   WIDTH_DEF = 4;
    localparam logic RST_BIT   = 1'b0;
    localparam logic [WIDTH_DEF-1:0] RST_VAL = {WIDTH_DEF{RST_BIT}};

endpackage

// File: rtl/t_ff_stage.sv
// One toggle flip-flop stage with synchronous reset.
// Latency: q updates on the same rising edge that samples t/rst.
// Backpressure: none; t is a plain per-edge enable.
module t_ff_stage
    import counter_pkg::*;
#(
    parameter logic RESET_BIT = RST_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_BIT;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/ripple_down_counter_4b.sv
// Down counter built from a chain of synchronous toggle stages, enabled by T.
// Latency: q updates on the edge that samples rst/T; rst has priority over T.
// Backpressure: none; T=0 freezes the count without losing it.
module ripple_down_counter_4b
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             rst,
    input  logic             T
);

    // Borrow chain: a stage toggles only when every lower bit is 0 and the
    // count is enabled. All stages share clk, so q never shows ripple states.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            logic stage_en;

            if (i == 0) begin : g_first
                assign stage_en = T;
            end else begin : g_chain
                assign stage_en = g_stage[i-1].stage_en & ~q[i-1];
            end

            t_ff_stage #(
                .RESET_BIT(RST_BIT)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .t   (stage_en),
                .q   (q[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ripple_down_counter_4b.sv
// Self-checking bench: directed sequences plus random rst/T against a
// modular-arithmetic reference of the down counter.
module tb_ripple_down_counter_4b;

    logic       clk;
    logic       rst;
    logic       t_in;
    logic [3:0] q;

    int   n_tests;
    int   n_fail;
    int   q_ref;
    time  last_edge;
    bit   mon_on;

    ripple_down_counter_4b dut (
        .q   (q),
        .clk (clk),
        .rst (rst),
        .T   (t_in)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d at t=%0t", tag, got, got, exp, $time);
        end
    endtask

    always @(posedge clk) last_edge = $time;

    // q may only move at a rising edge of clk.
    always @(q) begin
        if (mon_on) chk("q_edge_only", 32'($time - last_edge), 32'd0);
    end

    // Apply inputs, take one edge, advance the reference, compare 1 time unit later.
    task automatic step(input logic r, input logic t, input string tag);
        rst  = r;
        t_in = t;
        @(posedge clk);
        if (r)      q_ref = 0;
        else if (t) q_ref = (q_ref + 15) % 16;
        #1;
        chk(tag, {28'd0, q}, q_ref[31:0]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        q_ref   = 0;
        mon_on  = 1'b0;
        rst     = 1'b1;
        t_in    = 1'b0;

        // 1: reset, then count down 15..12
        step(1'b1, 1'b0, "reset");
        mon_on = 1'b1;
        chk("reset_zero", {28'd0, q}, 32'd0);
        step(1'b0, 1'b1, "first_count");
        chk("first_is_15", {28'd0, q}, 32'd15);
        repeat (3) step(1'b0, 1'b1, "count");
        chk("at_12", {28'd0, q}, 32'd12);

        // 2: hold, then resume
        repeat (3) step(1'b0, 1'b0, "hold");
        step(1'b0, 1'b1, "resume");
        chk("at_11", {28'd0, q}, 32'd11);
        step(1'b0, 1'b1, "resume2");

        // 3: reset mid-count while T=1, then release
        step(1'b1, 1'b1, "rst_mid");
        chk("rst_mid_zero", {28'd0, q}, 32'd0);
        step(1'b0, 1'b1, "after_rst");
        chk("after_rst_15", {28'd0, q}, 32'd15);
        step(1'b0, 1'b1, "after_rst2");

        // 4: wrap from 1 -> 0 -> 15, then full cycle of 16 from 15
        while (q_ref != 1) step(1'b0, 1'b1, "to_one");
        step(1'b0, 1'b1, "wrap_zero");
        chk("wrap_is_0", {28'd0, q}, 32'd0);
        step(1'b0, 1'b1, "wrap_15");
        chk("wrap_is_15", {28'd0, q}, 32'd15);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, "full_cycle");
        chk("cycle_back_15", {28'd0, q}, 32'd15);

        // 5: reset priority with T=0; pulses between edges are ignored
        step(1'b1, 1'b0, "rst_t0");
        chk("rst_t0_zero", {28'd0, q}, 32'd0);
        step(1'b0, 1'b1, "pre_pulse");
        rst = 1'b0; t_in = 1'b0;
        #3 rst = 1'b1; #3 rst = 1'b0;
        #2 t_in = 1'b1; #3 t_in = 1'b0;
        #1 chk("pulse_no_effect", {28'd0, q}, q_ref[31:0]);
        step(1'b0, 1'b0, "post_pulse_hold");
        chk("post_pulse_15", {28'd0, q}, 32'd15);

        // 6: random stimulus against the reference
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), "random");
        end

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1, "timeout");
    end

endmodule
